alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers. It is the sequential companion
//  to the combinational execute-stage ALU in the 5-stage pipeline. It handles MULT, MULTU,
//  DIV, DIVU, MTHI and MTLO, and holds HI/LO for MFHI/MFLO. The pipeline stalls while busy=1.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; even, >=4
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous reset, active-high
//  start     in   1      request; sampled only when accepting
//  op        in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  A         in   WIDTH  multiplicand/dividend, or MTHI/MTLO data
//  B         in   WIDTH  multiplier/divisor
//  flush     in   1      abort in-flight op (pipeline exception/branch squash)
//  busy      out  1      operation in flight; HI/LO not yet valid
//  done      out  1      one-cycle pulse; HI/LO updated this cycle
//  div_zero  out  1      valid with done: divisor was zero
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  - rst (any state, overrides all): state=IDLE; hi=lo=0; busy=done=div_zero=0; counter=0.
//  - States: IDLE, ITER, FIX, DONE. Accepting = state IDLE or DONE (back-to-back allowed).
//  - Accepting & start & op in {MULT..DIVU}: latch |A|,|B| (signed ops) or A,B, plus
//    result signs; go to ITER with counter=WIDTH-1.
//  - DIV/DIVU with B==0: go straight to DONE. done=1, div_zero=1, hi/lo unchanged.
//  - Accepting & start & MTHI/MTLO: hi (resp. lo) <= A at that edge; stay IDLE; done stays 0.
//  - Unsupported op is ignored. start while busy is ignored (no queueing).
//  - ITER, one step per cycle, WIDTH steps:
//    - mul: radix-2 shift-add into a 2*WIDTH accumulator.
//    - div: restoring shift-subtract.
//    - At counter==0, go to FIX.
//  - FIX, one cycle:
//    - Signed mul: negate the 2*WIDTH product if sign(A)^sign(B).
//    - Signed div: quotient sign = sign(A)^sign(B); remainder sign = sign(A).
//    - hi/lo written at the FIX->DONE edge.
//  - Mul result: {hi,lo} = full 2*WIDTH product. Div result: lo = quotient, hi = remainder.
//  - Signed MIN / -1: lo=MIN, hi=0 (falls out of abs/negate; no trap).
//  - Latency: done=1 in the WIDTH+2nd cycle after the accept edge (34 for WIDTH=32).
//  - busy=1 in ITER and FIX. busy=0 in IDLE and DONE.
//  - DONE lasts one cycle, then IDLE unless a new op is accepted.
//  - flush: in ITER/FIX, go to IDLE next edge; hi/lo unchanged; no done.
//    In IDLE/DONE, flush has no effect on state, but it blocks acceptance that cycle.
//    flush and start in the same cycle: flush wins.
//  - div_zero is cleared on every accept and is held until the next accept.
// STRUCTURE
//  - Shared include md_defs.vh: op encodings (OP_MULT..OP_MTLO) and state encodings.
//  - One sub-module, md_step: combinational single-iteration datapath.
//    - Inputs: mode, accumulator, operand.
//    - Output: next accumulator.
//    - Used for both shift-add and shift-subtract.
//  - Top level holds the FSM, counter, sign/abs logic, FIX negation and HI/LO registers.
// TESTING (WIDTH=32)
//  1. MULT A=FFFFFFFD, B=00000007 -> done at cycle 34, hi=FFFFFFFF, lo=FFFFFFEB.
//     MULTU A=B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//  2. DIV A=FFFFFFF9, B=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU A=7, B=2 -> lo=3, hi=1.
//     DIV A=80000000, B=FFFFFFFF -> lo=80000000, hi=0.
//  3. DIV A=5, B=0 with hi=lo=AAAA5555 preloaded via MTHI/MTLO
//     -> done and div_zero in cycle 2, hi/lo unchanged.
//  4. MULT, then flush in ITER cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//     start+MTHI while busy -> hi unchanged.
//  5. MULTU 3x5 with a second start held in the DONE cycle
//     -> lo=F, second op accepted, second done 34 cycles later.
//  6. rst asserted mid-DIV -> next cycle hi=lo=0, busy=done=div_zero=0;
//     a new op then completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Contents: operation encodings, FSM state encodings, datapath mode
// constants and small op-decode helpers used by the top level.
package alu_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // True for the four iterative arithmetic operations.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the operations that work on sign-magnitude operands.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // True for the divide operations.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_md_step.sv
// md_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   i_mode    - MODE_MUL: radix-2 shift-add, MODE_DIV: restoring shift-subtract
//   i_acc     - 2*WIDTH accumulator ({partial, multiplier} or {remainder, dividend/quotient})
//   i_operand - multiplicand (mul) or divisor (div), unsigned magnitude
//   o_acc     - accumulator after this iteration
module md_step
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_mode,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Single shift-add or shift-subtract step.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set; keep the carry.
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
        // Divide: remainder shifted left with the next dividend bit, one bit wider
        // so the trial subtraction's sign bit tells us whether it fits.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_operand};
        if (i_mode == MODE_MUL) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   start, op     - request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   A, B          - operands (A is also MTHI/MTLO data)
//   flush         - abort in-flight op; also blocks acceptance that cycle
//   busy          - op in flight (ITER/FIX)
//   done          - one-cycle pulse when HI/LO have been updated
//   div_zero      - with done: divisor was zero; held until next accept
//   hi, lo        - HI/LO registers
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_mode;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accepting;
    logic               w_take;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (r_mode),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_acc_next)
    );

    // Accept decode, operand magnitudes and FIX-stage sign correction.
    always_comb begin
        w_accepting = (r_state == ST_IDLE) || (r_state == ST_DONE);
        // flush beats start; unsupported ops are never taken.
        w_take      = w_accepting && start && !flush
                    && (is_arith_op(op) || (op == OP_MTHI) || (op == OP_MTLO));
        w_signed    = is_signed_op(op);
        // MIN maps to itself, which is the correct unsigned magnitude.
        w_a_abs     = (w_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        w_b_abs     = (w_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        w_prod_fix  = r_neg_q ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        w_quot_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
        w_rem_fix   = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration counter, datapath registers and HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_mode     <= MODE_MUL;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (w_take) begin
                        r_div_zero <= 1'b0;
                        if (op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == OP_MTLO) begin
                            r_lo <= A;
                        end else begin
                            r_mode  <= is_div_op(op) ? MODE_DIV : MODE_MUL;
                            r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_r <= w_signed && A[WIDTH-1];
                            r_cnt   <= CW'(WIDTH - 1);
                            if (is_div_op(op)) begin
                                r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
                                r_opnd <= w_b_abs;
                            end else begin
                                r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
                                r_opnd <= w_a_abs;
                            end
                            if (is_div_op(op) && (B == '0)) begin
                                // Divide by zero completes immediately, HI/LO untouched.
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_div_zero <= 1'b1;
                            end else begin
                                r_state <= ST_ITER;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                end
                ST_ITER: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == '0) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    r_busy <= 1'b0;
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        if (r_mode == MODE_MUL) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
